// File: rtl/stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stall_ctrl_pkg
// Purpose  : Shared types and encodings for the pipeline hazard controller.
//            Defines the stall bus, its three legal encodings, the divider
//            sequencer state encoding and the EX shadow-slot record.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package stall_ctrl_pkg;

  // One bit per pipeline register: [0] PC, [1] IF, [2] ID, [3] EX,
  // [4] MEM, [5] WB. A set bit holds that register.
  typedef logic [5:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  // Load-use: freeze PC, IF/ID and ID; EX takes a bubble.
  localparam stall_bus_t STALL_LU   = 6'b000111;
  // Divide: EX is frozen too so the div stays put while it iterates.
  localparam stall_bus_t STALL_DIV  = 6'b001111;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Shadow copy of the instruction currently in EX.
  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] waddr;
    logic       is_load;
    logic       is_div;
  } ex_slot_t;

endpackage : stall_ctrl_pkg
`default_nettype wire

// File: rtl/stall_ctrl_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Sequencer for the multi-cycle divider. Issues a one-cycle start
//            pulse, counts DIV_LAT busy cycles, then a one-cycle done pulse.
// Ports    : clk       - pipeline clock
//            rst       - synchronous active-high reset
//            start_req - a div is sitting in EX
//            busy      - sequencer active (includes the start cycle)
//            start     - one-cycle start pulse to the divider
//            done      - one-cycle pulse, divider result valid in EX
// Revision : 1.0 - initial release
// ============================================================================
module div_seq
  import stall_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start_req,
  output logic busy,
  output logic start,
  output logic done
);

  localparam logic [5:0] CNT_INIT = 6'(DIV_LAT - 1);

  div_state_t state, state_nxt;
  logic [5:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DIV_IDLE;
      cnt   <= 6'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    start     = 1'b0;
    done      = 1'b0;
    busy      = (state != DIV_IDLE);
    case (state)
      DIV_IDLE: begin
        if (start_req) begin
          start     = 1'b1;
          busy      = 1'b1;
          cnt_nxt   = CNT_INIT;
          state_nxt = DIV_BUSY;
        end
      end
      DIV_BUSY: begin
        // Decrement is gated at zero so the counter can never wrap.
        if (cnt == 6'd0) begin
          state_nxt = DIV_DONE;
        end else begin
          cnt_nxt = cnt - 6'd1;
        end
      end
      DIV_DONE: begin
        done      = 1'b1;
        state_nxt = DIV_IDLE;
      end
      default: begin
        state_nxt = DIV_IDLE;
      end
    endcase
  end

endmodule : div_seq
`default_nettype wire

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stall_ctrl
// Purpose  : Pipeline hazard controller. Shadows the instruction in EX,
//            detects load-use hazards the bypass network cannot cover, and
//            sequences the multi-cycle divider; drives the stall vector.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            id_valid          - ID holds a real instruction
//            id_re1/id_raddr1  - operand-1 read enable / address
//            id_re2/id_raddr2  - operand-2 read enable / address
//            id_we/id_waddr    - ID destination write enable / address
//            id_is_load        - ID instruction is a load
//            id_is_div         - ID instruction is div/divu
//            stall             - per-stage hold vector [5:0]
//            div_start         - one-cycle start pulse to the divider
//            div_done          - one-cycle pulse, divider result valid
//            div_busy          - divider sequencer active
// Revision : 1.0 - initial release
// ============================================================================
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int DIV_LAT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic       id_re1,
  input  logic [4:0] id_raddr1,
  input  logic       id_re2,
  input  logic [4:0] id_raddr2,
  input  logic       id_we,
  input  logic [4:0] id_waddr,
  input  logic       id_is_load,
  input  logic       id_is_div,
  output stall_bus_t stall,
  output logic       div_start,
  output logic       div_done,
  output logic       div_busy
);

  ex_slot_t slot, slot_nxt;
  logic     lu_cand;
  logic     lu;
  logic     div_stall;

  // ---------------- EX shadow slot ----------------
  always_comb begin
    slot_nxt = slot;
    if (stall[3]) begin
      slot_nxt = slot;
    end else if (stall[2]) begin
      slot_nxt = '0;
    end else begin
      slot_nxt.valid   = id_valid;
      slot_nxt.we      = id_valid & id_we;
      slot_nxt.waddr   = id_valid ? id_waddr : 5'd0;
      slot_nxt.is_load = id_valid & id_is_load;
      slot_nxt.is_div  = id_valid & id_is_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else begin
      slot <= slot_nxt;
    end
  end

  // ---------------- Load-use detection ----------------
  // Only a load in EX hurts: once it reaches MEM its data is bypassed.
  // $0 is hard-wired, so a load targeting it never creates a hazard.
  assign lu_cand = slot.valid & slot.is_load & slot.we & (slot.waddr != 5'd0);
  assign lu      = lu_cand & id_valid &
                   ((id_re1 & (id_raddr1 == slot.waddr)) |
                    (id_re2 & (id_raddr2 == slot.waddr)));

  // ---------------- Divider sequencer ----------------
  div_seq #(
    .DIV_LAT(DIV_LAT)
  ) u_div_seq (
    .clk      (clk),
    .rst      (rst),
    .start_req(slot.valid & slot.is_div),
    .busy     (div_busy),
    .start    (div_start),
    .done     (div_done)
  );

  // busy covers start, BUSY and DONE; DONE releases EX so the div can leave.
  assign div_stall = div_busy & ~div_done;

  // ---------------- Priority mux ----------------
  always_comb begin
    stall = STALL_NONE;
    if (div_stall) begin
      stall = STALL_DIV;
    end else if (lu) begin
      stall = STALL_LU;
    end
  end

endmodule : stall_ctrl
`default_nettype wire
